// File: rtl/prog_run_sequencer_if.sv
// Sequencer <-> harness/core signal bundle: Go/CpuAck in, core control and
// per-program cycle reports out.
`default_nettype none

interface prog_run_sequencer_if #(
    parameter int CW = 16
);
    logic          Go;
    logic          CpuAck;
    logic          CpuReset;
    logic          CpuStart;
    logic [3:0]    ProgIdx;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] CycleCount;
    logic          CountValid;
    logic          Timeout;

    modport master (
        input  Go, CpuAck,
        output CpuReset, CpuStart, ProgIdx, Busy, Done, CycleCount, CountValid, Timeout
    );

    modport slave (
        output Go, CpuAck,
        input  CpuReset, CpuStart, ProgIdx, Busy, Done, CycleCount, CountValid, Timeout
    );
endinterface

`default_nettype wire

// File: rtl/prog_run_sequencer.sv
// Runs NUM_PROGS programs on the CPU core back to back and reports per-program cycle counts.
// Optional watchdog on hung programs: define PROG_RUN_SEQUENCER_TIMEOUT_EN.
`default_nettype none

module prog_run_sequencer #(
    parameter int NUM_PROGS  = 3,
    parameter int RST_CYCLES = 2,
    parameter int CW         = 16,
    parameter int TIMEOUT    = 60000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    prog_run_sequencer_if.master bus
);
    localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] run_inc;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          done_q, done_d;
    logic          tmo_q, tmo_d;
    logic          cpurst_q, start_q, busy_q, valid_q;

    // Saturating increment; with the watchdog enabled the limit is never reached.
    assign run_inc = (run_q == {CW{1'b1}}) ? run_q : run_q + 1'b1;

`ifndef PROG_RUN_SEQUENCER_TIMEOUT_EN
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        run_d   = run_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Go) begin
                    idx_d   = '0;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    rcnt_d  = RW'(RST_CYCLES);
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                rcnt_d = rcnt_q - 1'b1;
                if (rcnt_q == RW'(1)) state_d = S_START;
            end
            S_START: begin
                run_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                run_d = run_inc;
                if (bus.CpuAck) begin
                    cyc_d   = run_inc;
                    state_d = S_REPORT;
                end
`ifdef PROG_RUN_SEQUENCER_TIMEOUT_EN
                else if (run_q == CW'(TIMEOUT - 1)) begin
                    cyc_d   = CW'(TIMEOUT);
                    tmo_d   = 1'b1;
                    state_d = S_REPORT;
                end
`endif
            end
            S_REPORT: begin
                if (idx_q == 4'(NUM_PROGS - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    rcnt_d  = RW'(RST_CYCLES);
                    state_d = S_RESET;
                end
            end
            S_FINISH: begin
                if (!bus.Go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            rcnt_q   <= '0;
            run_q    <= '0;
            idx_q    <= '0;
            cyc_q    <= '0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            cpurst_q <= 1'b1;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            run_q    <= run_d;
            idx_q    <= idx_d;
            cyc_q    <= cyc_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            cpurst_q <= !(state_d == S_START || state_d == S_RUN);
            start_q  <= (state_d == S_START);
            busy_q   <= (state_d == S_RESET) || (state_d == S_START) ||
                        (state_d == S_RUN)   || (state_d == S_REPORT);
            valid_q  <= (state_d == S_REPORT);
        end
    end

    assign bus.CpuReset   = cpurst_q;
    assign bus.CpuStart   = start_q;
    assign bus.ProgIdx    = idx_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.CycleCount = cyc_q;
    assign bus.CountValid = valid_q;
`ifdef PROG_RUN_SEQUENCER_TIMEOUT_EN
    assign bus.Timeout    = tmo_q;
`else
    assign bus.Timeout    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_run_sequencer.sv
// Scoreboarded bench: a core model acks after a per-program delay; reports are checked against expectations.
`default_nettype none

module tb_prog_run_sequencer;
    localparam int NUM_PROGS  = 3;
    localparam int RST_CYCLES = 2;
    localparam int CW         = 16;
    localparam int TIMEOUT    = 10;
    localparam int NEVER      = 1000000;
`ifdef PROG_RUN_SEQUENCER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    prog_run_sequencer_if #(.CW(CW)) bus ();

    prog_run_sequencer #(
        .NUM_PROGS (NUM_PROGS),
        .RST_CYCLES(RST_CYCLES),
        .CW        (CW),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.master)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    int exp_idx_q[$];
    int exp_cnt_q[$];

    int ack_at[NUM_PROGS];
    bit ack_hold = 1'b0;
    int k        = NEVER;
    int cur_ack  = NEVER;
    int starts   = 0;
    int rw       = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Core model + monitor, sampled mid-cycle.
    always @(negedge Clk) begin
        if (Reset) begin
            k  = NEVER;
            rw = 0;
        end else begin
            if (bus.CountValid) begin
                if (exp_idx_q.size() == 0) begin
                    check("unexpected_countvalid", 1, 0);
                end else begin
                    check("report_progidx", bus.ProgIdx, exp_idx_q.pop_front());
                    check("report_cyclecount", bus.CycleCount, exp_cnt_q.pop_front());
                end
            end
            if (bus.CpuStart) begin
                check("reset_window_before_start", rw, RST_CYCLES);
                starts++;
                k       = 0;
                cur_ack = (int'(bus.ProgIdx) < NUM_PROGS) ? ack_at[int'(bus.ProgIdx)] : NEVER;
                rw      = 0;
            end else begin
                if (k < NEVER) k++;
                if (bus.Busy && bus.CpuReset && !bus.CountValid) rw++;
                else rw = 0;
            end
        end
        bus.CpuAck = ack_hold || (k == cur_ack);
    end

    task automatic run_seq(input bit go_hold);
        bit exp_tmo;
        int cyc;
        exp_tmo = 1'b0;
        for (int p = 0; p < NUM_PROGS; p++) begin
            int c;
            if (ack_hold) c = 1;
            else if (TMO_EN && ack_at[p] > TIMEOUT) begin
                c = TIMEOUT;
                exp_tmo = 1'b1;
            end else c = ack_at[p];
            exp_idx_q.push_back(p);
            exp_cnt_q.push_back(c);
        end
        starts = 0;
        @(negedge Clk) bus.Go = 1'b1;
        @(negedge Clk);
        if (!go_hold) bus.Go = 1'b0;
        check("done_cleared_on_go", bus.Done, 0);
        check("timeout_cleared_on_go", bus.Timeout, 0);
        check("busy_after_go", bus.Busy, 1);
        cyc = 0;
        while (!bus.Done && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
        end
        check("sequence_done", bus.Done, 1);
        check("busy_low_at_done", bus.Busy, 0);
        check("timeout_flag", bus.Timeout, exp_tmo);
        check("starts_per_sequence", starts, NUM_PROGS);
        check("scoreboard_drained", exp_idx_q.size(), 0);
        if (go_hold) begin
            repeat (6) @(negedge Clk);
            check("no_restart_busy", bus.Busy, 0);
            check("no_restart_done", bus.Done, 1);
            check("no_restart_starts", starts, NUM_PROGS);
            bus.Go = 1'b0;
        end
        repeat (2) @(negedge Clk);
        check("done_holds_in_idle", bus.Done, 1);
        check("timeout_holds_in_idle", bus.Timeout, exp_tmo);
    endtask

    initial begin
        int cyc;
        bus.Go = 1'b0;
        Reset  = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_cpureset", bus.CpuReset, 1);
        check("rst_cpustart", bus.CpuStart, 0);
        check("rst_progidx", bus.ProgIdx, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_cyclecount", bus.CycleCount, 0);
        check("rst_countvalid", bus.CountValid, 0);
        check("rst_timeout", bus.Timeout, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Fixed ack on the 5th RUN cycle.
        for (int p = 0; p < NUM_PROGS; p++) ack_at[p] = 5;
        run_seq(1'b0);

        // Ack held high everywhere: ignored until RUN.
        ack_hold = 1'b1;
        run_seq(1'b0);
        ack_hold = 1'b0;

        // Randomized ack delays.
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < NUM_PROGS; p++) ack_at[p] = int'($urandom_range(1, 14));
            run_seq(1'b0);
        end

`ifdef PROG_RUN_SEQUENCER_TIMEOUT_EN
        ack_at[0] = 4; ack_at[1] = NEVER; ack_at[2] = 6;
        run_seq(1'b0);
        ack_at[0] = 10; ack_at[1] = 3; ack_at[2] = 10;
        run_seq(1'b0);
        ack_at[0] = 7; ack_at[1] = NEVER; ack_at[2] = 2;
        run_seq(1'b0);
`endif

        // Async reset in the middle of program 1's RUN.
        for (int p = 0; p < NUM_PROGS; p++) ack_at[p] = 8;
        exp_idx_q.push_back(0);
        exp_cnt_q.push_back(8);
        @(negedge Clk) bus.Go = 1'b1;
        @(negedge Clk) bus.Go = 1'b0;
        cyc = 0;
        while (!(bus.CpuStart && bus.ProgIdx == 4'd1) && cyc < 200) begin
            @(negedge Clk);
            cyc++;
        end
        check("reached_prog1_start", bus.ProgIdx, 1);
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_cpureset", bus.CpuReset, 1);
        check("async_rst_busy", bus.Busy, 0);
        check("async_rst_countvalid", bus.CountValid, 0);
        check("async_rst_progidx", bus.ProgIdx, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("no_report_after_reset", exp_idx_q.size(), 0);
        exp_idx_q.delete();
        exp_cnt_q.delete();

        for (int p = 0; p < NUM_PROGS; p++) ack_at[p] = int'($urandom_range(1, 9));
        run_seq(1'b0);

        // Go held through FINISH, then a fresh sequence.
`ifdef PROG_RUN_SEQUENCER_TIMEOUT_EN
        ack_at[0] = 3; ack_at[1] = NEVER; ack_at[2] = 3;
`else
        for (int p = 0; p < NUM_PROGS; p++) ack_at[p] = 3;
`endif
        run_seq(1'b1);
        for (int p = 0; p < NUM_PROGS; p++) ack_at[p] = 6;
        run_seq(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
